// File: rtl/data_mem_ctrl_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, stall, done, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, stall, done, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: one load/store per request, programmable wait states,
// pipeline stall while busy, one-cycle done/err pulse on completion.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned LIM_W      = ADDR_W + 1;
  localparam logic [LIM_W-1:0] ADDR_LIMIT = LIM_W'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rd;
  logic              lat_wr;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] ram [DEPTH_WORDS];

  logic              req;
  logic              in_idle;
  logic              go_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_bad;
  logic [IDX_W-1:0]  acc_idx;

  assign req     = bus.mem_read | bus.mem_write;
  assign in_idle = (state == IDLE);

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  assign acc_addr  = in_idle ? bus.addr      : lat_addr;
  assign acc_wdata = in_idle ? bus.wdata     : lat_wdata;
  assign acc_rd    = in_idle ? bus.mem_read  : lat_rd;
  assign acc_wr    = in_idle ? bus.mem_write : lat_wr;

  assign go_resp = (in_idle && req && (WAIT_CYCLES == 0)) ||
                   ((state == BUSY) && (cnt == '0));

  assign acc_bad = (acc_addr[1:0] != 2'b00) ||
                   ({1'b0, acc_addr} >= ADDR_LIMIT) ||
                   (acc_rd && acc_wr);

  assign acc_idx = acc_addr[IDX_W+1:2];

  assign bus.stall = (in_idle && req) || (state == BUSY);
  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= go_resp;
      err_q  <= go_resp && acc_bad;
      if (go_resp && acc_bad) begin
        rdata_q <= '0;
      end else if (go_resp && acc_rd) begin
        rdata_q <= ram[acc_idx];
      end

      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_rd    <= bus.mem_read;
            lat_wr    <= bus.mem_write;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is never cleared; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst_n && go_resp && !acc_bad && acc_wr) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 and 0 wait states) checked every cycle
// against a cycle-count based model, plus directed literal expectations.
module tb_data_mem_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus_a ();
  data_mem_ctrl_if bus_b ();

  data_mem_ctrl #(.WAIT_CYCLES(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  data_mem_ctrl #(.WAIT_CYCLES(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        o_stall [2];
  logic        o_done  [2];
  logic        o_err   [2];
  logic [31:0] o_rdata [2];

  assign bus_a.mem_read  = rd[0];
  assign bus_a.mem_write = wr[0];
  assign bus_a.addr      = ad[0];
  assign bus_a.wdata     = wd[0];
  assign bus_b.mem_read  = rd[1];
  assign bus_b.mem_write = wr[1];
  assign bus_b.addr      = ad[1];
  assign bus_b.wdata     = wd[1];
  assign o_stall[0] = bus_a.stall;
  assign o_done[0]  = bus_a.done;
  assign o_err[0]   = bus_a.err;
  assign o_rdata[0] = bus_a.rdata;
  assign o_stall[1] = bus_b.stall;
  assign o_done[1]  = bus_b.done;
  assign o_err[1]   = bus_b.err;
  assign o_rdata[1] = bus_b.rdata;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Model: a request seen while idle in cycle c completes (done) in cycle c+W+1.
  longint      cyc = 0;
  bit          seen_rst = 1'b0;
  bit          pend    [2] = '{1'b0, 1'b0};
  longint      resp    [2];
  bit          p_rd    [2];
  bit          p_wr    [2];
  logic [31:0] p_ad    [2];
  logic [31:0] p_wd    [2];
  bit          m_done  [2];
  bit          m_err   [2];
  bit          m_known [2];
  logic [31:0] m_rdata [2];
  logic [31:0] mem [int];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic step(input int d);
    bit bad;
    int key;
    if (!rst_n) begin
      pend[d] = 1'b0; m_done[d] = 1'b0; m_err[d] = 1'b0;
      m_rdata[d] = '0; m_known[d] = 1'b1; seen_rst = 1'b1;
      return;
    end
    if (!(pend[d] && cyc <= resp[d]) && (rd[d] || wr[d])) begin
      pend[d] = 1'b1;
      resp[d] = cyc + wait_of(d) + 1;
      p_rd[d] = rd[d]; p_wr[d] = wr[d]; p_ad[d] = ad[d]; p_wd[d] = wd[d];
    end
    m_done[d] = 1'b0;
    m_err[d]  = 1'b0;
    if (pend[d] && (cyc + 1 == resp[d])) begin
      m_done[d] = 1'b1;
      bad = (p_ad[d][1:0] != 2'b00) || (p_ad[d] >= 32'd1024) || (p_rd[d] && p_wr[d]);
      if (bad) begin
        m_err[d] = 1'b1; m_rdata[d] = '0; m_known[d] = 1'b1;
      end else begin
        key = d * 4096 + int'(p_ad[d] >> 2);
        if (p_rd[d]) begin
          if (mem.exists(key)) begin
            m_rdata[d] = mem[key]; m_known[d] = 1'b1;
          end else begin
            m_known[d] = 1'b0;
          end
        end else begin
          mem[key] = p_wd[d];
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) step(d);
      cyc++;
    end
  end

  // Compare every cycle once the first reset edge has defined the DUT state.
  initial begin
    bit exp_stall;
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        for (int d = 0; d < 2; d++) begin
          exp_stall = (pend[d] && cyc < resp[d]) ||
                      (!(pend[d] && cyc <= resp[d]) && (rd[d] || wr[d]));
          chk($sformatf("stall_dut%0d", d), 32'(o_stall[d]), 32'(exp_stall));
          chk($sformatf("done_dut%0d", d),  32'(o_done[d]),  32'(m_done[d]));
          chk($sformatf("err_dut%0d", d),   32'(o_err[d]),   32'(m_err[d]));
          if (m_known[d]) chk($sformatf("rdata_dut%0d", d), o_rdata[d], m_rdata[d]);
        end
      end
    end
  end

  task automatic do_req(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] dat,
                        output int lat, output logic [31:0] rv, output logic e);
    @(posedge clk); #1;
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
    lat = -1; rv = 'x; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        ad[d] = ~a;
        wd[d] = ~dat;
      end
      @(negedge clk);
      if (o_done[d]) begin
        lat = i; rv = o_rdata[d]; e = o_err[d];
        break;
      end
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rv;
    logic        e;
    logic [3:0]  pat;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", o_rdata[0], 32'h0);
    chk("reset_stall", 32'(o_stall[0]), 32'h0);

    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rv, e);
    chk("store_latency", 32'(lat), 32'd3);
    chk("store_err", 32'(e), 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rv, e);
    chk("load_latency", 32'(lat), 32'd3);
    chk("load_rdata", rv, 32'hDEADBEEF);
    chk("model_load_rdata", m_rdata[0], 32'hDEADBEEF);

    do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, rv, e);
    chk("misalign_err", 32'(e), 32'h1);
    chk("misalign_rdata", rv, 32'h0);
    chk("misalign_latency", 32'(lat), 32'd3);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rv, e);
    chk("reload_rdata", rv, 32'hDEADBEEF);

    do_req(0, 1'b0, 1'b1, 32'h400, 32'h1, lat, rv, e);
    chk("range_err", 32'(e), 32'h1);
    do_req(0, 1'b1, 1'b1, 32'h10, 32'h12345678, lat, rv, e);
    chk("double_err", 32'(e), 32'h1);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rv, e);
    chk("unchanged_rdata", rv, 32'hDEADBEEF);

    do_req(0, 1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, lat, rv, e);
    chk("top_store_err", 32'(e), 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0, lat, rv, e);
    chk("top_load_rdata", rv, 32'hA5A5A5A5);
    chk("top_load_err", 32'(e), 32'h0);

    // Abandoned store: reset lands while the store is still waiting.
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h11, lat, rv, e);
    @(posedge clk); #1;
    wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h55;
    @(posedge clk); #1;
    wr[0] = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_stall", 32'(o_stall[0]), 32'h0);
    chk("midrst_done", 32'(o_done[0]), 32'h0);
    repeat (3) @(posedge clk);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rv, e);
    chk("midrst_load", rv, 32'h11);

    do_req(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, lat, rv, e);
    chk("zw_store_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    rd[1] = 1'b1; ad[1] = 32'h10;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = o_done[1];
    end
    @(posedge clk); #1;
    rd[1] = 1'b0;
    chk("zw_done_pattern", 32'(pat), 32'hA);
    chk("zw_rdata", o_rdata[1], 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
